// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that drains an 8-bit synchronous FIFO, one byte per frame.
// Pops only from IDLE, so FIFO reads are throttled to the line rate.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              state, state_n;
  logic [BAUD_W-1:0]   baud, baud_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [DATA_W-1:0]   shift, shift_n;
  logic                tx_q, tx_n;
  logic                baud_last;

  assign baud_last = (baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_q    <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    case (state)
      S_IDLE: begin
        if (tx_en && !fifo_empty) state_n = S_POP;
      end
      S_POP: begin
        shift_n   = fifo_data;
        baud_n    = '0;
        bit_idx_n = '0;
        state_n   = S_START;
      end
      S_START: begin
        baud_n = baud_last ? '0 : baud + BAUD_W'(1);
        if (baud_last) begin
          bit_idx_n = '0;
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        baud_n = baud_last ? '0 : baud + BAUD_W'(1);
        if (baud_last) begin
          shift_n   = shift >> 1;
          bit_idx_n = bit_idx + 3'd1;
          // the index wraps 7->0 here, but the state leaves DATA on the same edge
          if (bit_idx == BIT_LAST) state_n = S_STOP;
        end
      end
      S_STOP: begin
        baud_n = baud_last ? '0 : baud + BAUD_W'(1);
        if (baud_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // line level is a function of where the FSM is going, so tx can be registered
    tx_n = 1'b1;
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // pop is combinational in IDLE; gated by rst_n so no read can slip out during reset
  assign fifo_rd_en = rst_n && (state == S_IDLE) && tx_en && !fifo_empty;
  assign busy       = (state != S_IDLE);
  assign tx_done    = (state == S_STOP) && baud_last;
  assign tx         = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, per-cycle frame-timing model and a line decoder.
module tb_fifo_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int          FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = '0;
  logic       fifo_rd_en, tx, busy, tx_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural FIFO, depth 8, registered read data and empty flag
  logic [7:0] fq[$];
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (fq.size() > 0) fifo_data <= fq.pop_front();
    end
    if (wr_en && fq.size() < 8) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
  end

  // Reference: a pop in cycle N owns the line for cycles N+1 .. N+1+FRAME
  int         fs = -1;
  logic [7:0] fb = '0;

  always @(negedge clk) begin : model
    logic e_tx, e_busy, e_done, e_rd;
    int   offs, k;
    e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0;
    if (!rst_n) begin
      fs = -1;
    end else begin
      if (fs >= 0 && cyc >= fs + 1 && cyc <= fs + 1 + FRAME) begin
        e_busy = 1'b1;
        offs = cyc - (fs + 2);
        if (offs >= 0) begin
          k = offs / CPB;
          if (k == 0)      e_tx = 1'b0;
          else if (k <= 8) e_tx = fb[k-1];
          else             e_tx = 1'b1;
        end
        e_done = (cyc == fs + 1 + FRAME);
      end
      e_rd = tx_en && !fifo_empty && !(fs >= 0 && cyc <= fs + 1 + FRAME);
    end
    chk("tx", tx, e_tx);
    chk("busy", busy, e_busy);
    chk("tx_done", tx_done, e_done);
    chk("fifo_rd_en", fifo_rd_en, e_rd);
    if (e_rd) begin
      fs = cyc;
      fb = fq[0];
    end
  end

  // Line decoder: samples mid-bit, pushes 10-bit frames {stop, data, start}
  logic [9:0] rx_q[$];
  int         rx_st[$];
  logic       in_fr = 1'b0;
  int         st = 0;
  logic [9:0] bits = '0;

  always @(negedge clk) begin : decoder
    int off;
    if (!rst_n) begin
      in_fr = 1'b0;
    end else begin
      if (!in_fr && tx == 1'b0) begin
        in_fr = 1'b1;
        st    = cyc;
        bits  = '0;
      end
      if (in_fr) begin
        off = cyc - st;
        if (off % CPB == CPB / 2) bits[off / CPB] = tx;
        if (off == FRAME - 1) begin
          in_fr = 1'b0;
          rx_q.push_back(bits);
          rx_st.push_back(st);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int c = 0;
    while (fq.size() >= 8 && c < 200) begin tick(); c++; end
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin tick(); c++; end
    if (rx_q.size() < n) chk("frame_timeout", rx_q.size(), n);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t       tbl[8];
  logic [7:0] rnd_q[$];

  initial begin
    int rd_before, c;
    tbl[0] = '{8'hAA, 10'b1101010100};
    tbl[1] = '{8'hBB, 10'b1101110110};
    tbl[2] = '{8'hCC, 10'b1110011000};
    tbl[3] = '{8'hDD, 10'b1110111010};
    tbl[4] = '{8'h55, 10'b1010101010};
    tbl[5] = '{8'hF0, 10'b1111100000};
    tbl[6] = '{8'h00, 10'b1000000000};
    tbl[7] = '{8'hFF, 10'b1111111110};

    // Reset with data waiting and tx_en high: nothing may pop
    tick();
    tx_en = 1'b1;
    push(8'hAA);
    repeat (3) tick();
    chk("reset_no_pop", rd_cnt, 0);
    chk("reset_fifo_kept", fq.size(), 1);
    rst_n = 1'b1;

    // Single byte
    wait_frames(1, 100);
    repeat (4) tick();
    chk("single_rd_cnt", rd_cnt, 1);
    chk("single_empty", fifo_empty, 1'b1);
    if (rx_q.size() > 0) chk("single_frame", rx_q.pop_front(), 10'b1101010100);
    rx_q.delete(); rx_st.delete();

    // Burst of 8 from the table: order, content and 42-cycle start spacing
    for (int i = 0; i < 8; i++) push(tbl[i].data);
    wait_frames(8, 8 * (FRAME + 2) + 50);
    for (int i = 0; i < 8; i++) begin
      if (rx_q.size() > 0) chk("burst_frame", rx_q.pop_front(), tbl[i].frame);
      if (i > 0 && rx_st.size() > i) chk("burst_spacing", rx_st[i] - rx_st[i-1], FRAME + 2);
    end
    repeat (5) tick();
    chk("burst_idle_tx", tx, 1'b1);
    chk("burst_rd_cnt", rd_cnt, 9);
    rx_q.delete(); rx_st.delete();

    // Pause: drop tx_en mid-frame, frame completes, no further pops
    push(8'h55);
    push(8'h66);
    c = 0;
    while (!busy && c < 50) begin tick(); c++; end
    repeat (10) tick();
    tx_en = 1'b0;
    rd_before = rd_cnt;
    wait_frames(1, 100);
    repeat (30) tick();
    chk("pause_no_pop", rd_cnt, rd_before);
    if (rx_q.size() > 0) chk("pause_frame", rx_q.pop_front(), 10'b1010101010);
    tx_en = 1'b1;
    wait_frames(1, 100);
    if (rx_q.size() > 0) chk("resume_frame", rx_q.pop_front(), 10'b1011001100);
    repeat (5) tick();
    rx_q.delete(); rx_st.delete();

    // Reset abort during DATA bit 3 of 0xF0
    rd_before = rd_cnt;
    push(8'hF0);
    push(8'h3C);
    c = 0;
    while (rd_cnt == rd_before && c < 50) begin tick(); c++; end
    repeat (18) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rd", fifo_rd_en, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_frames(1, 100);
    if (rx_q.size() > 0) chk("after_abort_frame", rx_q.pop_front(), 10'b1001111000);
    repeat (5) tick();
    rx_q.delete(); rx_st.delete();

    // Randomised traffic with tx_en toggling; per-cycle model checks throughout
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 5) == 0 && fq.size() < 8) begin
        logic [7:0] b;
        b = 8'($urandom);
        rnd_q.push_back(b);
        push(b);
      end else begin
        tick();
      end
    end
    tx_en = 1'b1;
    c = 0;
    while (!(fq.size() == 0 && !busy && !fifo_rd_en) && c < 6000) begin tick(); c++; end
    chk("drain_done", (fq.size() == 0 && !busy), 1'b1);
    repeat (4) tick();
    chk("rand_count", rx_q.size(), rnd_q.size());
    while (rx_q.size() > 0 && rnd_q.size() > 0)
      chk("rand_frame", rx_q.pop_front(), {1'b1, rnd_q.pop_front(), 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
